// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback-latency clamp used by the scoreboard.
package cpu_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int MAX_LAT_DEF  = 4;
    localparam int REG_W        = $clog2(NUM_REGS_DEF);
    localparam int LAT_W        = $clog2(MAX_LAT_DEF + 1);

    // A latency of 0 is treated as 1 (result is still one writeback away);
    // anything beyond the pipeline depth is held at the deepest stage.
    function automatic int clamp_lat(input int lat, input int max_lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > max_lat) begin
            return max_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: cycles remaining until this register's pending write lands.
module sb_entry
    import cpu_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic [LW-1:0] cnt,
    output logic          busy
);

    logic [LW-1:0] eff_lat;

    assign eff_lat = LW'(clamp_lat(int'(lat), MAX_LAT));
    assign busy    = (cnt != '0);

    // A new write restarts the countdown and takes priority over the decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= eff_lat;
        end else if (cnt != '0) begin
            cnt <= cnt - LW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode/execute interlock: RAW and WAW stall, writeback bypass selects,
// per-register busy view and a saturating stall counter.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic                         issue_writes,
    input  logic [$clog2(NUM_REGS)-1:0]  issue_rd,
    input  logic [$clog2(MAX_LAT+1)-1:0] issue_lat,
    input  logic                         src1_used,
    input  logic [$clog2(NUM_REGS)-1:0]  src1_addr,
    input  logic                         src2_used,
    input  logic [$clog2(NUM_REGS)-1:0]  src2_addr,
    input  logic                         flush,
    output logic                         stall,
    output logic                         src1_fwd,
    output logic                         src2_fwd,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic [CNT_W-1:0]             stall_count
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int LW = $clog2(MAX_LAT + 1);

    // Padded to a power of two so any address decodes; unused slots read 0.
    logic [LW-1:0] cnt_arr [2**AW];
    logic [LW-1:0] eff_lat;
    logic [LW-1:0] cnt_s1;
    logic [LW-1:0] cnt_s2;
    logic [LW-1:0] cnt_rd;
    logic          hit1;
    logic          hit2;
    logic          raw_stall;
    logic          waw_stall;
    logic          issue_fire;

    assign eff_lat    = LW'(clamp_lat(int'(issue_lat), MAX_LAT));
    assign issue_fire = issue_valid & ~stall & ~flush;

    genvar r;
    generate
        for (r = 0; r < 2**AW; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign cnt_arr[r] = '0;
                assign busy_vec[r] = 1'b0;
            end else if (r >= NUM_REGS) begin : g_pad
                assign cnt_arr[r] = '0;
            end else begin : g_entry
                sb_entry #(
                    .MAX_LAT(MAX_LAT),
                    .LW     (LW)
                ) u_entry (
                    .clk (clk),
                    .rst (rst),
                    .load(issue_fire & issue_writes & (issue_rd == AW'(r))),
                    .lat (issue_lat),
                    .cnt (cnt_arr[r]),
                    .busy(busy_vec[r])
                );
            end
        end
    endgenerate

    // Interlock: a source one cycle from writeback is bypassed, further out it stalls;
    // a shorter write to a still-pending rd waits so writebacks retire in order.
    always_comb begin
        cnt_s1    = cnt_arr[src1_addr];
        cnt_s2    = cnt_arr[src2_addr];
        cnt_rd    = cnt_arr[issue_rd];
        hit1      = src1_used & (src1_addr != '0) & (cnt_s1 != '0);
        hit2      = src2_used & (src2_addr != '0) & (cnt_s2 != '0);
        src1_fwd  = hit1 & (cnt_s1 == LW'(1));
        src2_fwd  = hit2 & (cnt_s2 == LW'(1));
        raw_stall = (hit1 & (cnt_s1 > LW'(1))) | (hit2 & (cnt_s2 > LW'(1)));
        waw_stall = issue_writes & (issue_rd != '0) & (eff_lat < cnt_rd);
        stall     = issue_valid & ~flush & (raw_stall | waw_stall);
    end

    // Stalled-cycle performance counter, pinned at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_writes, src1_used, src2_used, flush;
    logic [2:0] issue_rd, issue_lat, src1_addr, src2_addr;
    logic       stall, src1_fwd, src2_fwd;
    logic [7:0] busy_vec;
    logic [15:0] stall_count;
    logic       stall_s, src1_fwd_s, src2_fwd_s;
    logic [7:0] busy_vec_s;
    logic [1:0] stall_count_s;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src1_used(src1_used),
        .src1_addr(src1_addr), .src2_used(src2_used), .src2_addr(src2_addr),
        .flush(flush), .stall(stall), .src1_fwd(src1_fwd), .src2_fwd(src2_fwd),
        .busy_vec(busy_vec), .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src1_used(src1_used),
        .src1_addr(src1_addr), .src2_used(src2_used), .src2_addr(src2_addr),
        .flush(flush), .stall(stall_s), .src1_fwd(src1_fwd_s), .src2_fwd(src2_fwd_s),
        .busy_vec(busy_vec_s), .stall_count(stall_count_s)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        f1;
        logic        f2;
        logic [7:0]  busy;
        logic [15:0] sc;
        logic [1:0]  ss;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cyc(input string name, input logic v, input logic w,
                       input logic [2:0] rd, input logic [2:0] lat,
                       input logic u1, input logic [2:0] a1,
                       input logic u2, input logic [2:0] a2,
                       input logic fl, input logic pulse_rst,
                       input logic e_stall, input logic e_f1, input logic e_f2,
                       input logic [7:0] e_busy, input logic [15:0] e_sc,
                       input logic [1:0] e_ss);
        exp_t e;
        @(posedge clk);
        #1;
        issue_valid  = v;
        issue_writes = w;
        issue_rd     = rd;
        issue_lat    = lat;
        src1_used    = u1;
        src1_addr    = a1;
        src2_used    = u2;
        src2_addr    = a2;
        flush        = fl;
        e.name = name; e.stall = e_stall; e.f1 = e_f1; e.f2 = e_f2;
        e.busy = e_busy; e.sc = e_sc; e.ss = e_ss;
        exp_q.push_back(e);
        if (pulse_rst) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
        end
    endtask

    task automatic idle(input string name, input logic [7:0] e_busy,
                        input logic [15:0] e_sc, input logic [1:0] e_ss);
        cyc(name, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, e_busy, e_sc, e_ss);
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_tests++;
                if (stall !== e.stall || src1_fwd !== e.f1 || src2_fwd !== e.f2 ||
                    busy_vec !== e.busy || stall_count !== e.sc ||
                    stall_s !== e.stall || src1_fwd_s !== e.f1 || src2_fwd_s !== e.f2 ||
                    busy_vec_s !== e.busy || stall_count_s !== e.ss) begin
                    n_fail++;
                    $display("FAIL %s: got stall=%b fwd=%b%b busy=%h cnt=%0d sat_stall=%b sat_fwd=%b%b sat_busy=%h sat_cnt=%0d; required stall=%b fwd=%b%b busy=%h cnt=%0d sat_cnt=%0d",
                             e.name, stall, src1_fwd, src2_fwd, busy_vec, stall_count,
                             stall_s, src1_fwd_s, src2_fwd_s, busy_vec_s, stall_count_s,
                             e.stall, e.f1, e.f2, e.busy, e.sc, e.ss);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_writes = 0; issue_rd = 0; issue_lat = 0;
        src1_used = 0; src1_addr = 0; src2_used = 0; src2_addr = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //   name            v w rd    lat   u1 a1   u2 a2   fl pr st f1 f2 busy   sc  ss
        cyc("reset_idle",    1,0,3'd0,3'd0, 1,3'd3, 0,3'd0, 0,0, 0,0,0, 8'h00, 0, 0);
        cyc("raw_issue",     1,1,3'd3,3'd3, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 0, 0);
        idle("raw_gap",                                             8'h08, 0, 0);
        cyc("raw_stall",     1,0,3'd0,3'd0, 1,3'd3, 1,3'd3, 0,0, 1,0,0, 8'h08, 0, 0);
        cyc("raw_fwd",       1,0,3'd0,3'd0, 1,3'd3, 1,3'd3, 0,0, 0,1,1, 8'h08, 1, 1);
        idle("raw_done",                                            8'h00, 1, 1);

        cyc("waw_first",     1,1,3'd5,3'd4, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 1, 1);
        cyc("waw_stall_c4",  1,1,3'd5,3'd1, 0,3'd0, 0,3'd0, 0,0, 1,0,0, 8'h20, 1, 1);
        cyc("waw_stall_c3",  1,1,3'd5,3'd1, 0,3'd0, 0,3'd0, 0,0, 1,0,0, 8'h20, 2, 2);
        cyc("waw_stall_c2",  1,1,3'd5,3'd1, 0,3'd0, 0,3'd0, 0,0, 1,0,0, 8'h20, 3, 3);
        cyc("waw_issue",     1,1,3'd5,3'd1, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h20, 4, 3);
        idle("waw_busy",                                            8'h20, 4, 3);
        idle("waw_clear",                                           8'h00, 4, 3);

        cyc("r0_issue",      1,1,3'd0,3'd4, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 4, 3);
        idle("r0_idle",                                             8'h00, 4, 3);
        cyc("flush_issue",   1,1,3'd2,3'd3, 0,3'd0, 0,3'd0, 1,0, 0,0,0, 8'h00, 4, 3);
        idle("flush_idle",                                          8'h00, 4, 3);

        cyc("clamp0_issue",  1,1,3'd4,3'd0, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 4, 3);
        cyc("clamp0_fwd",    1,0,3'd0,3'd0, 1,3'd4, 0,3'd0, 0,0, 0,1,0, 8'h10, 4, 3);
        idle("clamp0_done",                                         8'h00, 4, 3);
        cyc("clamp7_issue",  1,1,3'd6,3'd7, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 4, 3);
        cyc("clamp7_flush",  1,0,3'd0,3'd0, 1,3'd6, 0,3'd0, 1,0, 0,0,0, 8'h40, 4, 3);
        cyc("clamp7_stall",  1,0,3'd0,3'd0, 1,3'd6, 0,3'd0, 0,0, 1,0,0, 8'h40, 4, 3);
        idle("clamp7_busy3",                                        8'h40, 5, 3);
        idle("clamp7_busy4",                                        8'h40, 5, 3);
        idle("clamp7_clear",                                        8'h00, 5, 3);

        cyc("rst_issue",     1,1,3'd3,3'd3, 0,3'd0, 0,3'd0, 0,0, 0,0,0, 8'h00, 5, 3);
        idle("rst_busy",                                            8'h08, 5, 3);
        cyc("rst_mid",       1,0,3'd0,3'd0, 1,3'd3, 0,3'd0, 0,1, 0,0,0, 8'h00, 0, 0);
        idle("rst_after",                                           8'h00, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
